// File: rtl/gen_fifo_display.sv
// gen_fifo_display
//   Word generator -> synchronous FIFO -> display register -> multiplexed
//   hexadecimal 7-segment display.
//
//   Parameters
//     DIGITS   : number of display digits, data width is 4*DIGITS
//     DEPTH    : FIFO depth in words (power of two, >= 2)
//     STEP     : generator increment per accepted write
//     SCAN_DIV : clock cycles each digit is held during the scan (>= 1)
//
//   Ports
//     CLK, RST : clock, synchronous active-high reset
//     Enwrk    : global work enable, 0 freezes every register
//     ENgen    : generator write request
//     ENraf    : FIFO read request (pops the head into the display register)
//     usedw    : words stored, 0..DEPTH
//     full     : usedw == DEPTH
//     empty    : usedw == 0
//     ovf      : sticky, set by a write request blocked at full
//     ss       : segments {g,f,e,d,c,b,a}, active-low
//     dig      : digit selects [DIGITS:1], one-hot active-low, dig[1] = LS nibble
module gen_fifo_display #(
  parameter int DIGITS   = 4,
  parameter int DEPTH    = 16,
  parameter int STEP     = 1,
  parameter int SCAN_DIV = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Enwrk,
  input  logic                     ENgen,
  input  logic                     ENraf,
  output logic [$clog2(DEPTH):0]   usedw,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  output logic [6:0]               ss,
  output logic [DIGITS:1]          dig
);

  localparam int DATA_W = 4 * DIGITS;
  localparam int AW     = $clog2(DEPTH);
  localparam int UW     = AW + 1;
  localparam int CW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DATA_W-1:0] STEP_V = DATA_W'(STEP);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] gen_val;
  logic [DATA_W-1:0] disp_reg;
  logic [CW-1:0]     scan_div;
  logic [IW-1:0]     dig_idx;
  logic              rd;
  logic              wr;
  logic [3:0]        nib;

  assign full  = (usedw == UW'(DEPTH));
  assign empty = (usedw == '0);

  // A read at full frees a slot in the same edge, so the write is allowed.
  assign rd = Enwrk & ENraf & ~empty;
  assign wr = Enwrk & ENgen & (~full | rd);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      usedw    <= '0;
      gen_val  <= '0;
      disp_reg <= '0;
      ovf      <= 1'b0;
      scan_div <= '0;
      dig_idx  <= '0;
    end else if (Enwrk) begin
      if (rd) begin
        disp_reg <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
      if (wr) begin
        wr_ptr  <= wr_ptr + AW'(1);
        gen_val <= gen_val + STEP_V;
      end
      case ({wr, rd})
        2'b10:   usedw <= usedw + UW'(1);
        2'b01:   usedw <= usedw - UW'(1);
        default: usedw <= usedw;
      endcase
      if (ENgen & full & ~rd) ovf <= 1'b1;

      if (scan_div == CW'(SCAN_DIV - 1)) begin
        scan_div <= '0;
        dig_idx  <= (dig_idx == IW'(DIGITS - 1)) ? '0 : dig_idx + IW'(1);
      end else begin
        scan_div <= scan_div + CW'(1);
      end
    end
  end

  // Storage is not reset; pointers alone define the valid contents.
  always_ff @(posedge CLK) begin
    if (wr & ~RST) mem[wr_ptr] <= gen_val;
  end

  assign nib = disp_reg[4*dig_idx +: 4];

  always_comb begin
    dig = '1;
    for (int k = 0; k < DIGITS; k++) begin
      dig[k+1] = (dig_idx != IW'(k));
    end
  end

  always_comb begin
    ss = 7'b1111111;
    case (nib)
      4'h0: ss = 7'b1000000;
      4'h1: ss = 7'b1111001;
      4'h2: ss = 7'b0100100;
      4'h3: ss = 7'b0110000;
      4'h4: ss = 7'b0011001;
      4'h5: ss = 7'b0010010;
      4'h6: ss = 7'b0000010;
      4'h7: ss = 7'b1111000;
      4'h8: ss = 7'b0000000;
      4'h9: ss = 7'b0010000;
      4'hA: ss = 7'b0001000;
      4'hB: ss = 7'b0000011;
      4'hC: ss = 7'b1000110;
      4'hD: ss = 7'b0100001;
      4'hE: ss = 7'b0000110;
      4'hF: ss = 7'b0001110;
      default: ss = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_gen_fifo_display.sv
module tb_gen_fifo_display;

  localparam int DIGITS   = 4;
  localparam int DEPTH    = 16;
  localparam int STEP     = 1;
  localparam int SCAN_DIV = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Enwrk = 1'b0;
  logic       ENgen = 1'b0;
  logic       ENraf = 1'b0;
  logic [4:0] usedw;
  logic       full, empty, ovf;
  logic [6:0] ss;
  logic [4:1] dig;

  // Second instance with a large step so the display can reach 0xA3F0 quickly.
  logic       rst2 = 1'b1;
  logic       wrk2 = 1'b0;
  logic       gen2 = 1'b0;
  logic       raf2 = 1'b0;
  logic [4:0] usedw2;
  logic       full2, empty2, ovf2;
  logic [6:0] ss2;
  logic [4:1] dig2;

  always #5 CLK = ~CLK;

  gen_fifo_display #(.DIGITS(DIGITS), .DEPTH(DEPTH), .STEP(STEP), .SCAN_DIV(SCAN_DIV)) u_dut (
    .CLK(CLK), .RST(RST), .Enwrk(Enwrk), .ENgen(ENgen), .ENraf(ENraf),
    .usedw(usedw), .full(full), .empty(empty), .ovf(ovf), .ss(ss), .dig(dig)
  );

  gen_fifo_display #(.DIGITS(4), .DEPTH(16), .STEP(16'hA3F0), .SCAN_DIV(4)) u_dut2 (
    .CLK(CLK), .RST(rst2), .Enwrk(wrk2), .ENgen(gen2), .ENraf(raf2),
    .usedw(usedw2), .full(full2), .empty(empty2), .ovf(ovf2), .ss(ss2), .dig(dig2)
  );

  typedef struct {
    logic [4:0] usedw;
    logic       full;
    logic       empty;
    logic       ovf;
    logic [6:0] ss;
    logic [4:1] dig;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   stim_done = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: FIFO as a queue, scan position from enabled-cycle count.
  logic [15:0] m_q[$];
  logic [15:0] m_gen = 0;
  logic [15:0] m_disp = 0;
  bit          m_ovf = 0;
  int          m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit wrk, input bit g, input bit r);
    bit can_rd, is_full, do_wr;
    if (rst) begin
      m_q.delete();
      m_gen  = 0;
      m_disp = 0;
      m_ovf  = 0;
      m_cnt  = 0;
    end else if (wrk) begin
      can_rd  = r && (m_q.size() > 0);
      is_full = (m_q.size() == DEPTH);
      do_wr   = g && (!is_full || can_rd);
      if (g && is_full && !can_rd) m_ovf = 1;
      if (can_rd) m_disp = m_q.pop_front();
      if (do_wr) begin
        m_q.push_back(m_gen);
        m_gen = m_gen + 16'(STEP);
      end
      m_cnt++;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   idx;
    idx     = (m_cnt / SCAN_DIV) % DIGITS;
    e.usedw = 5'(m_q.size());
    e.full  = (m_q.size() == DEPTH);
    e.empty = (m_q.size() == 0);
    e.ovf   = m_ovf;
    e.ss    = seg_tab[(m_disp >> (4 * idx)) & 16'hF];
    e.dig   = ~(4'b0001 << idx);
    return e;
  endfunction

  task automatic drive(input bit rst, input bit wrk, input bit g, input bit r);
    @(negedge CLK);
    RST   = rst;
    Enwrk = wrk;
    ENgen = g;
    ENraf = r;
    model_step(rst, wrk, g, r);
    exp_q.push_back(model_out());
  endtask

  // Monitor: every expectation pushed at a negedge is due just after the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("usedw", 32'(usedw), 32'(e.usedw));
        check("flags", {29'd0, full, empty, ovf}, {29'd0, e.full, e.empty, e.ovf});
        check("ss", 32'(ss), 32'(e.ss));
        check("dig", 32'(dig), 32'(e.dig));
      end
    end
  end

  task automatic drive2(input bit rst, input bit wrk, input bit g, input bit r);
    @(negedge CLK);
    rst2 = rst;
    wrk2 = wrk;
    gen2 = g;
    raf2 = r;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [6:0] a3f0_ss  [4] = '{7'b1000000, 7'b0001110, 7'b0110000, 7'b0001000};
    logic [3:0] a3f0_dig [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int wait_cnt;

    // Scenario 1..5: directed sequences
    repeat (2) drive(1, 0, 0, 0);
    repeat (18) drive(0, 1, 1, 0);
    repeat (18) drive(0, 1, 0, 1);
    repeat (27) drive(0, 1, 1, 1);
    repeat (3)  drive(0, 0, 1, 1);
    repeat (5)  drive(0, 1, 1, 1);
    drive(1, 1, 1, 1);
    repeat (4)  drive(0, 1, 1, 0);
    repeat (6)  drive(0, 1, 0, 1);

    // Randomized traffic with occasional resets and freezes
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 60; i++) begin
      drive(0, 1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
    end
    stim_done = 1;

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge CLK);
      wait_cnt++;
    end
    #2;
    check("drain", 32'(exp_q.size()), 32'd0);

    // Scenario 6: display register 0xA3F0 on the second instance
    drive2(1, 0, 0, 0);
    check("dig2_reset", 32'(dig2), 32'b1110);
    check("ss2_reset", 32'(ss2), 32'b1000000);
    drive2(0, 1, 1, 0);   // writes 0x0000
    drive2(0, 1, 1, 1);   // reads 0x0000, writes 0xA3F0
    drive2(0, 1, 0, 1);   // reads 0xA3F0; 3 enabled edges so far
    for (int n = 4; n < 20; n++) begin
      drive2(0, 1, 0, 0);
      check("dig2_scan", 32'(dig2), 32'(a3f0_dig[(n / 4) % 4]));
      check("ss2_scan", 32'(ss2), 32'(a3f0_ss[(n / 4) % 4]));
    end
    check("usedw2", 32'(usedw2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gen_fifo_display.md
# gen_fifo_display

Parametrised data-path block: an internal word generator writes into a synchronous FIFO, a read port pops words into a display register, and the register is shown in hexadecimal on a multiplexed 7-segment display. It generalises the fixed 4-digit generator/FIFO/display chain to configurable data width, FIFO depth, digit count, scan rate and generator step. It adds full/empty/overflow status and simultaneous read/write at full. It sits at board top level, driven directly by switch enables.

## Interface
- `DIGITS` — default 4 — number of display digits; `DATA_W = 4*DIGITS`.
- `DEPTH` — default 16 — FIFO depth in words; power of two, ≥2.
- `STEP` — default 1 — generator increment per accepted write, modulo 2^DATA_W.
- `SCAN_DIV` — default 4 — clock cycles per digit in the display scan; ≥1.
- `CLK` — in — 1 — single clock; all state changes on the rising edge.
- `RST` — in — 1 — reset, synchronous, active-high.
- `Enwrk` — in — 1 — global work enable; 0 freezes all state.
- `ENgen` — in — 1 — generator write request.
- `ENraf` — in — 1 — FIFO read request.
- `usedw` — out — $clog2(DEPTH)+1 — words currently stored, 0..DEPTH.
- `full` — out — 1 — `usedw == DEPTH`.
- `empty` — out — 1 — `usedw == 0`.
- `ovf` — out — 1 — sticky overflow flag.
- `ss` — out — 7 — segments {g,f,e,d,c,b,a}, active-low.
- `dig` — out — DIGITS (`[DIGITS:1]`) — digit selects, one-hot, active-low; `dig[1]` = least significant nibble.

## Operation
- `RST=1` at an edge clears the following: generator value to 0, FIFO pointers to 0, `usedw` to 0, display register to 0, `ovf` to 0, scan divider to 0, digit index to 0. Reset takes priority over `Enwrk`.
- Reset output values:
  - `usedw=0`, `empty=1`, `full=0`, `ovf=0`.
  - `dig` = all ones except `dig[1]=0`.
  - `ss=7'b1000000` (glyph "0").
- `Enwrk=0`: generator, FIFO, flags, display register, scan divider and digit index all hold. Outputs remain stable.
- Read fires when `Enwrk & ENraf & !empty`.
  - The head word is loaded into the display register.
  - The read pointer advances, wrapping modulo DEPTH.
- Write fires when `Enwrk & ENgen & (!full | rd)`.
  - The current generator value is stored at the write pointer.
  - The write pointer advances, wrapping modulo DEPTH.
  - The generator advances by STEP.
- The generator advances only on an accepted write. Blocked requests never skip values.
- Simultaneous read and write, including at full: both occur and `usedw` is unchanged.
- Read while empty: ignored. The display register holds, and a simultaneous write still occurs.
- `ovf` is set when `Enwrk & ENgen & full & !rd`. It is cleared only by `RST`.
- Display scan:
  - The divider counts 0..SCAN_DIV-1 while `Enwrk=1`.
  - On wrap, the digit index advances 0..DIGITS-1 and then wraps to 0.
  - Digit index k drives `dig[k+1]=0` and decodes nibble k (bits 4k+3:4k) of the display register.
- Hex decoding is standard for 0–F; A, b, C, d, E, F use lowercase b and d.

## Timing
- All outputs are registered or decoded from registers. No combinational path from the enable inputs to any output.
- `usedw`, `full`, `empty` and `ovf` reflect an edge's read/write in the cycle after that edge.
- Write-to-read latency: a word written at edge n is readable at edge n+1 if it is the head. Its value appears on the display register, and on `ss` when its digit is scanned, after edge n+1.
- Each digit is held for exactly SCAN_DIV enabled cycles. A full scan takes DIGITS·SCAN_DIV enabled cycles.
- Pointer wrap at DEPTH is seamless. `usedw` saturates logically at DEPTH by the write-blocking rule and never wraps.
- `RST` asserted mid-operation: all state returns to reset values at that edge, with the outputs listed above visible in the next cycle. FIFO contents are discarded and pointers are reset; memory need not be cleared.

## Test plan
Default parameters: DIGITS=4, DEPTH=16, STEP=1, SCAN_DIV=4.

1. Reset, then `ENgen=Enwrk=1`, `ENraf=0` for 18 cycles:
   - `usedw` counts 1..16; `full=1` after 16 writes.
   - `ovf=1` after the 17th edge.
   - Stored words are 0x0000..0x000F.
2. From scenario 1, `ENgen=0`, `ENraf=1` for 18 cycles:
   - Reads return 0x0000..0x000F in order.
   - `usedw` falls to 0, `empty=1`, display register = 0x000F.
   - The 2 extra reads are ignored and `ovf` stays 1.
3. From scenario 2, all enables = 1 for 27 cycles:
   - First cycle: write only (empty), `usedw=1`.
   - Afterwards `usedw` stays 1.
   - Display register tracks generator values 0x0010, 0x0011, … with one-cycle lag.
4. `Enwrk=0` for 3 cycles with `ENgen=ENraf=1`: `usedw`, display register, `dig` and `ss` are unchanged on every edge.
5. `RST=1` mid-stream with all enables = 1:
   - Next cycle: `usedw=0`, `empty=1`, `ovf=0`, `dig=4'b1110`, `ss=7'b1000000`.
   - After release, the generator restarts at 0x0000.
6. Display register = 0xA3F0 with `Enwrk=1`:
   - `dig` cycles 1110 → 1101 → 1011 → 0111, each for 4 cycles.
   - `ss` shows 0, F, 3, A: 1000000, 0001110, 0110000, 0001000.
